// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-save accumulator.
package csa_pkg;

  localparam int MODE_ACC   = 0;
  localparam int MODE_SHIFT = 1;
  localparam int MAX_W      = 64;

  // Sign-extend the low in_w bits of v across the whole MAX_W word.
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int in_w);
    return MAX_W'($signed(v << (MAX_W - in_w)) >>> (MAX_W - in_w));
  endfunction

  function automatic bit acc_w_ok(input int acc_w, input int in_w);
    return (acc_w >= in_w + 1) && (acc_w <= MAX_W);
  endfunction

endpackage

// File: rtl/compressor_42_row.sv
// One row of 4:2 compressor cells; horizontal carries depend only on x/y/z, so no ripple.
module compressor_42_row #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] w,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic             cout
);

  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] s1;

  assign chain[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s1[i]      = x[i] ^ y[i] ^ z[i];
    assign chain[i+1] = (x[i] & y[i]) | (x[i] & z[i]) | (y[i] & z[i]);
    assign s[i]       = s1[i] ^ w[i] ^ chain[i];
    // c[i] carries weight 2^(i+1); the caller shifts it into place.
    assign c[i]       = (s1[i] & w[i]) | (s1[i] & chain[i]) | (w[i] & chain[i]);
  end

  assign cout = chain[WIDTH];

endmodule

// File: rtl/csa_accumulator_42.sv
// Carry-save accumulator: one 4:2 row per beat, one carry-propagate add per sequence.
module csa_accumulator_42
  import csa_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int MODE  = MODE_ACC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_neg,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             err
);

  localparam int STAGES = 1;

  if (!acc_w_ok(ACC_W, IN_W)) begin : g_bad_width
    $error("csa_accumulator_42: ACC_W must be >= IN_W + 1 and <= 64");
  end

  logic [ACC_W-1:0] s_q, c_q;
  logic [ACC_W-1:0] a_ext, b_ext, a_op, b_op;
  logic [ACC_W-1:0] base_s, base_c;
  logic [ACC_W-1:0] row_s, row_c;
  logic             row_cout;
  logic             busy_q;
  logic             accept;
  logic [STAGES:0]  vld_pipe;

  assign accept = in_valid & (busy_q | in_first);

  assign a_ext = ACC_W'(sext(MAX_W'(in_a), IN_W));
  assign b_ext = ACC_W'(sext(MAX_W'(in_b), IN_W));
  // Negation = invert both operands; the two +1s enter at ci and the free C[0] slot.
  assign a_op  = in_neg ? ~a_ext : a_ext;
  assign b_op  = in_neg ? ~b_ext : b_ext;

  assign base_s = in_first ? '0 : (MODE == MODE_SHIFT) ? (s_q << 1) : s_q;
  assign base_c = in_first ? '0 : (MODE == MODE_SHIFT) ? (c_q << 1) : c_q;

  compressor_42_row #(.WIDTH(ACC_W)) u_row (
    .x    (a_op),
    .y    (b_op),
    .z    (base_s),
    .w    (base_c),
    .ci   (in_neg),
    .s    (row_s),
    .c    (row_c),
    .cout (row_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= '0;
      c_q      <= '0;
      busy_q   <= 1'b0;
      vld_pipe <= '0;
      out_data <= '0;
      err      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept & in_last};
      err      <= in_valid & ~busy_q & ~in_first;
      // vld_pipe[0] marks that S/C now hold a finished sequence.
      if (vld_pipe[STAGES-1])
        out_data <= s_q + c_q;
      if (accept) begin
        s_q    <= row_s;
        c_q    <= {row_c[ACC_W-2:0], in_neg};
        busy_q <= ~in_last;
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign busy      = busy_q;

endmodule
